cv32e40px_irq_arbiter: RTL and testbench

- Programmable-priority scheduler for the 16 custom "fast" interrupt lines, irq[31:16], in front of the core's interrupt controller.
- Per-line functions:
  - captures edge- or level-type sources into pending bits;
  - arbitrates by per-line priority above a global threshold;
  - presents exactly one one-hot request on irq_o.
- Holds that request until the core acknowledges it, then retires it.

---
 rtl/cv32e40px_irq_arbiter.sv | 154 +++++++++++++++
 tb/tb_cv32e40px_irq_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40px_irq_arbiter
// Description : Programmable-priority scheduler for the 16 fast interrupt
//               lines irq[31:16]; presents one held one-hot request per ack.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40px_irq_arbiter #(
   parameter  int NUM_IRQ = 16,
   parameter  int PRIO_W  = 3,
   localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src_i,
   input  logic               cfg_we_i,
   input  logic [IDX_W-1:0]   cfg_idx_i,
   input  logic               cfg_en_i,
   input  logic               cfg_edge_i,
   input  logic [PRIO_W-1:0]  cfg_prio_i,
   input  logic [PRIO_W-1:0]  thresh_i,
   output logic [31:0]        irq_o,
   input  logic               irq_ack_i,
   input  logic [4:0]         irq_ack_id_i,
   output logic               busy_o,
   output logic [4:0]         sel_id_o,
   output logic [NUM_IRQ-1:0] pend_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   logic [NUM_IRQ-1:0] r_en;
   logic [NUM_IRQ-1:0] r_edge;
   logic [PRIO_W-1:0]  r_prio [NUM_IRQ];
   logic [NUM_IRQ-1:0] r_src_q;
   logic [NUM_IRQ-1:0] r_pend;
   state_t             r_state;
   logic [IDX_W-1:0]   r_sel;
   logic [4:0]         r_sel_id;
   logic [31:0]        r_irq;

   logic               w_idx_ok;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_elig;
   logic [NUM_IRQ-1:0] w_clr;
   logic               w_any;
   logic [IDX_W-1:0]   w_win;
   logic [PRIO_W-1:0]  w_win_prio;
   logic               w_ack_hit;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   w_sel_nxt;
   logic [4:0]         w_id_nxt;
   logic [31:0]        w_irq_nxt;

   assign w_idx_ok = (int'(cfg_idx_i) < NUM_IRQ);
   assign w_rise   = irq_src_i & ~r_src_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en   <= '0;
         r_edge <= '0;
         for (int i = 0; i < NUM_IRQ; i++) r_prio[i] <= '0;
      end else if (cfg_we_i && w_idx_ok) begin
         r_en[cfg_idx_i]   <= cfg_en_i;
         r_edge[cfg_idx_i] <= cfg_edge_i;
         r_prio[cfg_idx_i] <= cfg_prio_i;
      end
   end

   // A new edge in the same cycle as retirement keeps the line pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_src_q <= '0;
         r_pend  <= '0;
      end else begin
         r_src_q <= irq_src_i;
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_edge[i]) r_pend[i] <= w_rise[i] | (r_pend[i] & ~w_clr[i]);
            else           r_pend[i] <= irq_src_i[i];
         end
      end
   end

   // Ascending scan with >= lets the highest index win a priority tie.
   always_comb begin
      w_elig     = '0;
      w_any      = 1'b0;
      w_win      = '0;
      w_win_prio = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         w_elig[i] = r_pend[i] & r_en[i] & (r_prio[i] > thresh_i);
         if (w_elig[i] && (!w_any || r_prio[i] >= w_win_prio)) begin
            w_any      = 1'b1;
            w_win      = i[IDX_W-1:0];
            w_win_prio = r_prio[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_clr       = '0;
      w_ack_hit   = irq_ack_i && (irq_ack_id_i == r_sel_id);
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_REQ;
               w_sel_nxt   = w_win;
            end
         end
         ST_REQ: begin
            if (w_ack_hit) begin
               w_state_nxt = ST_CLEAR;
               if (r_edge[r_sel]) w_clr[r_sel] = 1'b1;
            end else if (!w_elig[r_sel]) begin
               w_state_nxt = ST_IDLE;
            end else if (w_win_prio > r_prio[r_sel]) begin
               w_sel_nxt = w_win;
            end
         end
         ST_CLEAR: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      w_id_nxt  = 5'd16 | 5'(w_sel_nxt);
      w_irq_nxt = '0;
      if (w_state_nxt == ST_REQ) w_irq_nxt[w_id_nxt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_sel_id <= '0;
         r_irq    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_sel_id <= (w_state_nxt == ST_REQ) ? w_id_nxt : 5'd0;
         r_irq    <= w_irq_nxt;
      end
   end

   assign irq_o    = r_irq;
   assign sel_id_o = r_sel_id;
   assign busy_o   = (r_state != ST_IDLE);
   assign pend_o   = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40px_irq_arbiter
// Description : Scoreboard bench for the fast-interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40px_irq_arbiter;

   localparam int NUM_IRQ = 16;
   localparam int PRIO_W  = 3;
   localparam int K_IRQ   = 0;
   localparam int K_PEND  = 1;
   localparam int K_BUSY  = 2;
   localparam int K_ID    = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NUM_IRQ-1:0] irq_src;
   logic               cfg_we;
   logic [3:0]         cfg_idx;
   logic               cfg_en;
   logic               cfg_edge;
   logic [PRIO_W-1:0]  cfg_prio;
   logic [PRIO_W-1:0]  thresh;
   logic [31:0]        irq_o;
   logic               irq_ack;
   logic [4:0]         irq_ack_id;
   logic               busy_o;
   logic [4:0]         sel_id_o;
   logic [NUM_IRQ-1:0] pend_o;

   cv32e40px_irq_arbiter #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_src_i    (irq_src),
      .cfg_we_i     (cfg_we),
      .cfg_idx_i    (cfg_idx),
      .cfg_en_i     (cfg_en),
      .cfg_edge_i   (cfg_edge),
      .cfg_prio_i   (cfg_prio),
      .thresh_i     (thresh),
      .irq_o        (irq_o),
      .irq_ack_i    (irq_ack),
      .irq_ack_id_i (irq_ack_id),
      .busy_o       (busy_o),
      .sel_id_o     (sel_id_o),
      .pend_o       (pend_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          cyc;
      string       tag;
      int          kind;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic expect_at(input int dly, input string tag, input int kind, input logic [31:0] val);
      exp_t e;
      e.cyc  = cyc + dly;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_IRQ:   return irq_o;
         K_PEND:  return 32'(pend_o);
         K_BUSY:  return 32'(busy_o);
         default: return 32'(sel_id_o);
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < sb.size();) begin
         if (sb[i].cyc <= cyc) begin
            check_val(sb[i].tag, observe(sb[i].kind), sb[i].val);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cfg(input int idx, input logic en, input logic edg, input int prio);
      cfg_we   = 1'b1;
      cfg_idx  = 4'(idx);
      cfg_en   = en;
      cfg_edge = edg;
      cfg_prio = PRIO_W'(prio);
      tick();
      cfg_we   = 1'b0;
   endtask

   // Ack in the current cycle: one CLEAR cycle, then one IDLE cycle.
   task automatic do_ack(input int id);
      irq_ack    = 1'b1;
      irq_ack_id = 5'(id);
      expect_at(1, "ack_clear_irq", K_IRQ, 32'd0);
      expect_at(1, "ack_clear_busy", K_BUSY, 32'd1);
      expect_at(2, "ack_idle_irq", K_IRQ, 32'd0);
      expect_at(2, "ack_idle_busy", K_BUSY, 32'd0);
      tick();
      irq_ack = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
      cfg_edge = 1'b0; cfg_prio = '0; thresh = '0; irq_ack = 1'b0; irq_ack_id = '0;
      ticks(2);
      expect_at(0, "rst_irq", K_IRQ, 32'd0);
      expect_at(0, "rst_pend", K_PEND, 32'd0);
      expect_at(0, "rst_busy", K_BUSY, 32'd0);
      expect_at(0, "rst_id", K_ID, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // basic edge request and latency
      cfg(3, 1'b1, 1'b1, 2);
      tick();
      irq_src[3] = 1'b1;
      expect_at(1, "t1_pend", K_PEND, 32'h0000_0008);
      expect_at(2, "t1_irq", K_IRQ, 32'h0008_0000);
      expect_at(2, "t1_busy", K_BUSY, 32'd1);
      expect_at(2, "t1_id", K_ID, 32'd19);
      tick();
      irq_src[3] = 1'b0;
      tick();

      // foreign ack ignored, matching ack retires
      irq_ack = 1'b1; irq_ack_id = 5'd11;
      expect_at(1, "t2_badack_irq", K_IRQ, 32'h0008_0000);
      expect_at(1, "t2_badack_pend", K_PEND, 32'h0000_0008);
      tick();
      irq_ack = 1'b0;
      expect_at(1, "t2_pend_clr", K_PEND, 32'd0);
      do_ack(19);

      // tie on priority, then preemption
      cfg(2, 1'b1, 1'b1, 1);
      cfg(5, 1'b1, 1'b1, 1);
      irq_src[2] = 1'b1; irq_src[5] = 1'b1;
      expect_at(2, "t3_tie", K_IRQ, 32'd1 << 21);
      tick();
      irq_src = '0;
      tick();
      cfg(7, 1'b1, 1'b1, 4);
      irq_src[7] = 1'b1;
      expect_at(0, "t3_hold0", K_IRQ, 32'd1 << 21);
      expect_at(1, "t3_hold1", K_IRQ, 32'd1 << 21);
      expect_at(2, "t3_preempt", K_IRQ, 32'd1 << 23);
      expect_at(2, "t3_preempt_id", K_ID, 32'd23);
      tick();
      irq_src = '0;
      tick();
      do_ack(23);
      expect_at(1, "t3_resume5", K_IRQ, 32'd1 << 21);
      tick();
      do_ack(21);
      expect_at(1, "t3_line2", K_IRQ, 32'd1 << 18);
      tick();
      do_ack(18);

      // threshold masking
      thresh = 3'd2;
      cfg(4, 1'b1, 1'b1, 2);
      irq_src[4] = 1'b1;
      expect_at(1, "t4_pend", K_PEND, 32'd1 << 4);
      expect_at(2, "t4_masked", K_IRQ, 32'd0);
      expect_at(3, "t4_masked2", K_IRQ, 32'd0);
      tick();
      irq_src = '0;
      ticks(2);
      thresh = 3'd1;
      expect_at(1, "t4_unmasked", K_IRQ, 32'd1 << 20);
      tick();
      do_ack(20);
      thresh = 3'd0;

      // level source drop
      cfg(0, 1'b1, 1'b0, 3);
      irq_src[0] = 1'b1;
      expect_at(1, "t5_pend", K_PEND, 32'd1);
      expect_at(2, "t5_level", K_IRQ, 32'd1 << 16);
      ticks(3);
      irq_src[0] = 1'b0;
      expect_at(1, "t5_hold", K_IRQ, 32'd1 << 16);
      expect_at(2, "t5_drop", K_IRQ, 32'd0);
      expect_at(2, "t5_drop_busy", K_BUSY, 32'd0);
      ticks(2);

      // new edge coinciding with ack
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      tick();
      expect_at(0, "t6_req", K_IRQ, 32'd1 << 19);
      irq_ack = 1'b1; irq_ack_id = 5'd19; irq_src[3] = 1'b1;
      expect_at(1, "t6_pend_kept", K_PEND, 32'h0000_0008);
      expect_at(1, "t6_clear", K_IRQ, 32'd0);
      expect_at(2, "t6_idle", K_IRQ, 32'd0);
      expect_at(3, "t6_rereq", K_IRQ, 32'd1 << 19);
      tick();
      irq_ack = 1'b0; irq_src[3] = 1'b0;
      ticks(2);
      do_ack(19);

      // reset while requesting
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      tick();
      expect_at(0, "t7_req", K_IRQ, 32'd1 << 19);
      rst_n = 1'b0;
      expect_at(1, "t7_rst_irq", K_IRQ, 32'd0);
      expect_at(1, "t7_rst_pend", K_PEND, 32'd0);
      expect_at(1, "t7_rst_busy", K_BUSY, 32'd0);
      expect_at(1, "t7_rst_id", K_ID, 32'd0);
      tick();
      rst_n = 1'b1;
      irq_src[3] = 1'b1;
      expect_at(1, "t7_level_pend", K_PEND, 32'h0000_0008);
      expect_at(2, "t7_disabled", K_IRQ, 32'd0);
      ticks(2);
      irq_src[3] = 1'b0;
      expect_at(1, "t7_level_follow", K_PEND, 32'd0);
      ticks(4);

      check_val("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
